// File: rtl/bsg_mesh_traffic_endpoint_if.sv
// Link between a mesh traffic endpoint and the P port of a bsg_mesh_router.
// The master side belongs to the endpoint and the slave side to the router.
// Packets use the format {payload, dest_y, dest_x}, with dest_x in the LSBs.
interface bsg_mesh_traffic_endpoint_if #(
    parameter int unsigned x_cord_width_p = 2,
    parameter int unsigned y_cord_width_p = 2,
    parameter int unsigned data_width_p   = 4
);
    localparam int unsigned packet_width_lp = data_width_p + y_cord_width_p + x_cord_width_p;

    // tx toward router P input
    logic                       v_o;
    logic [packet_width_lp-1:0] data_o;
    logic                       ready_and_i;

    // rx from router P output
    logic                       v_i;
    logic [packet_width_lp-1:0] data_i;
    logic                       yumi_o;
    logic                       rx_stall_i;

    modport master (
        output v_o, data_o, yumi_o,
        input  ready_and_i, v_i, data_i, rx_stall_i
    );

    modport slave (
        input  v_o, data_o, yumi_o,
        output ready_and_i, v_i, data_i, rx_stall_i
    );
endinterface

// File: rtl/bsg_mesh_traffic_endpoint.sv
// Mesh traffic source/sink for a router P port.
// The tx side sends a burst of packets that sweeps every mesh destination in
// raster order. The rx side consumes arriving packets, counts them, XORs
// their payloads and flags any packet not addressed to this tile.
// When BSG_MESH_ENDPOINT_SKIP_SELF_EN is defined, the sweep skips this
// tile's own coordinates.
module bsg_mesh_traffic_endpoint #(
    parameter int unsigned x_cord_width_p = 2,
    parameter int unsigned y_cord_width_p = 2,
    parameter int unsigned data_width_p   = 4,
    parameter int unsigned x_dim_p        = 4,
    parameter int unsigned y_dim_p        = 4,
    parameter int unsigned num_packets_p  = 16,
    parameter int unsigned count_width_p  = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic                      start_i,
    bsg_mesh_traffic_endpoint_if.master link,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [count_width_p-1:0]  sent_count_o,
    output logic [count_width_p-1:0]  recv_count_o,
    output logic [data_width_p-1:0]   checksum_o,
    output logic                      err_o
);
    localparam int unsigned xw_lp     = x_cord_width_p;
    localparam int unsigned yw_lp     = y_cord_width_p;
    localparam int unsigned cord_w_lp = xw_lp + yw_lp;
    localparam int unsigned dw_lp     = data_width_p;
    localparam int unsigned pkt_w_lp  = dw_lp + cord_w_lp;
    localparam int unsigned cw_lp     = count_width_p;

    localparam logic [xw_lp-1:0] x_last_lp   = xw_lp'(x_dim_p - 1);
    localparam logic [yw_lp-1:0] y_last_lp   = yw_lp'(y_dim_p - 1);
    localparam logic [cw_lp-1:0] last_cnt_lp = cw_lp'(num_packets_p - 1);

    typedef enum logic [1:0] {
        s_idle = 2'd0,
        s_send = 2'd1,
        s_done = 2'd2
    } state_e;

    state_e                 state_r, state_n;
    logic [cord_w_lp-1:0]   ptr_r, ptr_n;
    logic [cw_lp-1:0]       sent_r, sent_n;
    logic                   v_r, busy_r, done_r;
    logic [cw_lp-1:0]       recv_r;
    logic [dw_lp-1:0]       chk_r;
    logic                   err_r;

    logic                   hs;
    logic                   yumi;
    logic [cord_w_lp-1:0]   self_cord;
    logic [cord_w_lp-1:0]   first_cord;
    logic [cord_w_lp-1:0]   next_cord;
    logic [dw_lp-1:0]       rx_payload;
    logic [cord_w_lp-1:0]   rx_dest;

    // Advance a {y,x} pointer one step in raster order, wrapping at the mesh size.
    function automatic logic [cord_w_lp-1:0] step_f(input logic [cord_w_lp-1:0] c);
        logic [xw_lp-1:0] x;
        logic [yw_lp-1:0] y;
        x = c[xw_lp-1:0];
        y = c[cord_w_lp-1:xw_lp];
        if (x == x_last_lp) begin
            x = '0;
            y = (y == y_last_lp) ? '0 : y + 1'b1;
        end else begin
            x = x + 1'b1;
        end
        return {y, x};
    endfunction

    assign self_cord = {my_y_i, my_x_i};

`ifdef BSG_MESH_ENDPOINT_SKIP_SELF_EN
    // Our own tile is never a destination. Because the mesh has at least two
    // tiles, one extra step always reaches a tile that is not ours.
    assign first_cord = (self_cord == '0) ? step_f('0) : '0;
    assign next_cord  = (step_f(ptr_r) == self_cord) ? step_f(step_f(ptr_r)) : step_f(ptr_r);
`else
    // Every tile in the sweep is a destination, including our own.
    assign first_cord = '0;
    assign next_cord  = step_f(ptr_r);
`endif

    assign hs          = v_r & link.ready_and_i;
    assign link.v_o    = v_r;
    assign link.data_o = pkt_w_lp'({sent_r[dw_lp-1:0], ptr_r});

    // Consume rx packets whenever they arrive unless stalled; hold off during reset.
    assign yumi        = reset_n_i & link.v_i & ~link.rx_stall_i;
    assign link.yumi_o = yumi;
    assign rx_payload  = link.data_i[pkt_w_lp-1:cord_w_lp];
    assign rx_dest     = link.data_i[cord_w_lp-1:0];

    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign sent_count_o = sent_r;
    assign recv_count_o = recv_r;
    assign checksum_o   = chk_r;
    assign err_o        = err_r;

    // Burst sequencing: next state, sweep pointer and sent count.
    always_comb begin
        state_n = state_r;
        ptr_n   = ptr_r;
        sent_n  = sent_r;
        unique case (state_r)
            s_idle, s_done: begin
                if (start_i) begin
                    state_n = s_send;
                    ptr_n   = first_cord;
                    sent_n  = '0;
                end
            end
            s_send: begin
                if (hs) begin
                    ptr_n = next_cord;
                    if (sent_r != '1) sent_n = sent_r + 1'b1;
                    if (sent_r == last_cnt_lp) state_n = s_done;
                end
            end
            default: state_n = s_idle;
        endcase
    end

    // Tx state register. The status outputs are registered from the next state.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= s_idle;
            ptr_r   <= '0;
            sent_r  <= '0;
            v_r     <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            sent_r  <= sent_n;
            v_r     <= (state_n == s_send);
            busy_r  <= (state_n == s_send);
            done_r  <= (state_n == s_done);
        end
    end

    // Rx bookkeeping: saturating receive count, payload XOR and sticky misroute flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            recv_r <= '0;
            chk_r  <= '0;
            err_r  <= 1'b0;
        end else if (yumi) begin
            if (recv_r != '1) recv_r <= recv_r + 1'b1;
            chk_r <= chk_r ^ rx_payload;
            if (rx_dest != self_cord) err_r <= 1'b1;
        end
    end
endmodule

// File: doc/bsg_mesh_traffic_endpoint.md
Name: bsg_mesh_traffic_endpoint

Overview:
- Synthesizable traffic source and sink that attaches to the P (proc) port of a bsg_mesh_router.
- Injects a fixed-length burst of packets that sweeps every mesh destination in raster order.
- Concurrently consumes packets delivered to this tile, counting them, checksumming payloads and flagging misrouted arrivals.
- Used as the stimulus/response endpoint for mesh bring-up and congestion tests.

Parameters:
- x_cord_width_p, 2, width of x coordinate
- y_cord_width_p, 2, width of y coordinate
- data_width_p, 4, payload width excluding coordinates
- x_dim_p, 4, mesh columns swept (1..2**x_cord_width_p)
- y_dim_p, 4, mesh rows swept (1..2**y_cord_width_p)
- num_packets_p, 16, packets per burst (>=1)
- count_width_p, 16, width of status counters

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- my_x_i  in  x_cord_width_p  this tile's x
- my_y_i  in  y_cord_width_p  this tile's y
- start_i  in  1  begin burst (sampled in IDLE/DONE only)
- v_o  out  1  tx valid toward router P input
- data_o  out  data_width_p+y_cord_width_p+x_cord_width_p  {payload, dest_y, dest_x}, dest_x in LSBs
- ready_and_i  in  1  router accepts tx packet
- v_i  in  1  rx valid from router P output
- data_i  in  same as data_o  rx packet, same format
- yumi_o  out  1  rx consumed this cycle
- rx_stall_i  in  1  suppress rx consumption
- busy_o  out  1  burst in progress
- done_o  out  1  burst complete
- sent_count_o  out  count_width_p  tx handshakes this burst
- recv_count_o  out  count_width_p  rx consumptions since reset
- checksum_o  out  data_width_p  XOR of all consumed payloads
- err_o  out  1  sticky: rx packet dest != my coords

Behaviour:
- Reset: async on reset_n_i low; all outputs 0 immediately; state IDLE; sweep pointer (0,0); all counters, checksum and err cleared. Takes effect mid-burst with no drain.
- FSM states: IDLE, SEND, DONE.
  - IDLE/DONE + start_i -> SEND; sent_count cleared; sweep pointer reset to (0,0).
  - SEND: start_i ignored; after num_packets_p-th handshake -> DONE.
- busy_o = (state==SEND); done_o = (state==DONE).
- Tx timing:
  - start_i high at cycle 0 -> v_o=1 at cycle 1.
  - v_o is registered and deasserts only on the cycle after the final handshake.
  - Handshake = v_o & ready_and_i.
  - data_o is stable while v_o & ~ready_and_i (no retraction, no change).
  - After each handshake the next packet is presented the following cycle; full throughput is 1 packet/cycle.
- Payload = sent_count[data_width_p-1:0] at issue, i.e. 0,1,2,… mod 2**data_width_p.
- Sweep:
  - dest_x increments per handshake; wraps x_dim_p-1 -> 0 and increments dest_y.
  - dest_y wraps y_dim_p-1 -> 0.
  - num_packets_p > x_dim_p*y_dim_p repeats the sweep.
- Rx:
  - yumi_o = v_i & ~rx_stall_i (combinational; no dependence on tx state).
  - Each yumi: recv_count+1, checksum ^= payload.
  - err_o set if dest fields != {my_y_i,my_x_i}; cleared only by reset.
- Counters saturate at all-ones, never wrap.
- Simultaneous tx handshake and rx consumption are independent and both take effect in the same cycle.

Optional Feature:
- Macro: BSG_MESH_ENDPOINT_SKIP_SELF_EN.
- Defined:
  - Any sweep destination equal to (my_x_i,my_y_i) is skipped, including the initial (0,0), with no packet and no count.
  - The next non-self destination is presented in the same cycle position.
  - Requires x_dim_p*y_dim_p >= 2.
- Undefined: self-addressed packets are sent like any other.

Test Plan:
- Throughput: me=(1,2), ready_and_i=1, start pulse at cycle 0 -> v_o high cycles 1–16; dests (0,0),(1,0),(2,0),(3,0),(0,1)…(3,3); payloads 0..15; done_o=1 and v_o=0 at cycle 17; sent_count_o=16.
- Backpressure and restart:
  - ready_and_i alternating 1/0 -> data_o unchanged across every stalled cycle; same 16-packet sequence; done after 32 cycles.
  - start_i during SEND is ignored.
  - start_i in DONE restarts at dest (0,0), payload 0.
- Rx checksum: five packets to (1,2) with payloads 1,2,4,8,3 -> recv_count_o=5, checksum_o=0xC, err_o=0. Then one packet addressed (0,0) -> err_o=1, which stays 1 through a later start.
- Rx stall: v_i held high with rx_stall_i=1 for 3 cycles -> yumi_o=0 and recv_count_o unchanged; rx_stall_i=0 -> yumi_o=1 the same cycle.
- Async reset: drop reset_n_i mid-cycle after 5 tx handshakes -> v_o, busy_o and all counters 0 without waiting for a clock edge. Release, then start -> first dest (0,0), payload 0.
- Skip self: macro defined, me=(0,0), num_packets_p=4 -> dests (1,0),(2,0),(3,0),(0,1); payloads 0..3.
